// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one word_ram port between the cpu data port (m0) and a
// secondary master (m1). Grants are decided combinationally within the cycle,
// alternate round-robin on contention, honour a per-master lock for atomic
// sequences and are bounded by a starvation limit (MAX_HOLD). Read data is
// registered and returned one cycle after the grant.
// Optional feature: define RAM_ARB_STATS_EN to add grant/conflict counters.
`timescale 1ns/1ps

module ram_arbiter #(
    parameter int unsigned ADDR_W   = 15,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req,
    input  logic              m0_lock,
    input  logic [3:0]        m0_we,
    input  logic [31:0]       m0_addr,
    input  logic [31:0]       m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [31:0]       m0_rdata,

    input  logic              m1_req,
    input  logic              m1_lock,
    input  logic [3:0]        m1_we,
    input  logic [31:0]       m1_addr,
    input  logic [31:0]       m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [31:0]       m1_rdata,

    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic [3:0]        ram_wenable,
    input  logic [31:0]       ram_rdata
`ifdef RAM_ARB_STATS_EN
    ,
    output logic [31:0]       stat_gnt0,
    output logic [31:0]       stat_gnt1,
    output logic [31:0]       stat_conflict
`endif
);

    localparam int unsigned HOLD_W = 8;
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } lock_e;

    lock_e              lock_own;
    logic               last;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [ADDR_W-1:0]  addr_q;
    logic [31:0]        wdata_q;

    logic               other_req_c;
    logic               starve_c;
    logic               gnt_any_c;
    logic               gnt_sel_c;
    logic               gnt_contended_c;
    logic               gnt_repeat_c;
    logic [HOLD_W-1:0]  hold_inc_c;

    // Only the word-address slice of each byte address reaches the RAM.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{m0_addr, m1_addr};

    // Starvation detect: the master that is not `last` is waiting while the
    // current owner has already used up its hold budget.
    always_comb begin
        other_req_c = last ? m0_req : m1_req;
        starve_c    = (hold_cnt == HOLD_MAX) && other_req_c;
    end

    // Grant selection: starvation override, then lock, then round-robin.
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (rst) begin
            m0_gnt = 1'b0;
            m1_gnt = 1'b0;
        end else if (starve_c) begin
            m0_gnt = last;
            m1_gnt = !last;
        end else begin
            case (lock_own)
                LOCK0: m0_gnt = m0_req;
                LOCK1: m1_gnt = m1_req;
                default: begin
                    if (m0_req && m1_req) begin
                        m0_gnt = last;
                        m1_gnt = !last;
                    end else begin
                        m0_gnt = m0_req;
                        m1_gnt = m1_req;
                    end
                end
            endcase
        end
    end

    // Grant summary used by the bookkeeping registers.
    always_comb begin
        gnt_any_c       = m0_gnt | m1_gnt;
        gnt_sel_c       = m1_gnt;
        gnt_contended_c = gnt_sel_c ? m0_req : m1_req;
        gnt_repeat_c    = (gnt_sel_c == last) && gnt_contended_c;
        hold_inc_c      = (hold_cnt == HOLD_MAX) ? HOLD_MAX : hold_cnt + HOLD_W'(1);
    end

    // RAM bus mux: the grantee drives the port; idle cycles hold addr/wdata
    // and never write.
    always_comb begin
        ram_addr    = addr_q;
        ram_wdata   = wdata_q;
        ram_wenable = 4'b0000;
        if (m0_gnt) begin
            ram_addr    = m0_addr[ADDR_W+1:2];
            ram_wdata   = m0_wdata;
            ram_wenable = m0_we;
        end else if (m1_gnt) begin
            ram_addr    = m1_addr[ADDR_W+1:2];
            ram_wdata   = m1_wdata;
            ram_wenable = m1_we;
        end
    end

    // Remember the last driven address/data for idle cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (gnt_any_c) begin
            addr_q  <= ram_addr;
            wdata_q <= ram_wdata;
        end
    end

    // Arbitration state: last grantee, lock owner and consecutive-hold count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last     <= 1'b1;
            lock_own <= IDLE;
            hold_cnt <= '0;
        end else if (gnt_any_c) begin
            last <= gnt_sel_c;
            if (starve_c) begin
                lock_own <= IDLE;
                hold_cnt <= '0;
            end else begin
                if (gnt_sel_c) begin
                    lock_own <= m1_lock ? LOCK1 : IDLE;
                end else begin
                    lock_own <= m0_lock ? LOCK0 : IDLE;
                end
                hold_cnt <= gnt_repeat_c ? hold_inc_c : '0;
            end
        end
    end

    // m0 read return: capture RAM data at the end of the granted cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m0_rvalid <= 1'b0;
            m0_rdata  <= '0;
        end else begin
            m0_rvalid <= m0_gnt && (m0_we == 4'b0000);
            if (m0_gnt && (m0_we == 4'b0000)) begin
                m0_rdata <= ram_rdata;
            end
        end
    end

    // m1 read return: capture RAM data at the end of the granted cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m1_rvalid <= 1'b0;
            m1_rdata  <= '0;
        end else begin
            m1_rvalid <= m1_gnt && (m1_we == 4'b0000);
            if (m1_gnt && (m1_we == 4'b0000)) begin
                m1_rdata <= ram_rdata;
            end
        end
    end

`ifdef RAM_ARB_STATS_EN
    logic conflict_c;

    // A cycle is a conflict when any requester is left waiting.
    always_comb begin
        conflict_c = (m0_req && !m0_gnt) || (m1_req && !m1_gnt);
    end

    // Free-running wrap-around statistics counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_gnt0     <= '0;
            stat_gnt1     <= '0;
            stat_conflict <= '0;
        end else begin
            if (m0_gnt) begin
                stat_gnt0 <= stat_gnt0 + 32'd1;
            end
            if (m1_gnt) begin
                stat_gnt1 <= stat_gnt1 + 32'd1;
            end
            if (conflict_c) begin
                stat_conflict <= stat_conflict + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus randomized traffic, all
// checked against a transaction-level model of the arbitration rules.
`timescale 1ns/1ps

module tb_ram_arbiter;

    localparam int unsigned ADDR_W   = 15;
    localparam int unsigned MAX_HOLD = 8;
    localparam int unsigned DEPTH    = 1 << ADDR_W;

    logic              clk;
    logic              rst;
    logic              m0_req, m0_lock, m1_req, m1_lock;
    logic [3:0]        m0_we, m1_we;
    logic [31:0]       m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic              m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0]       m0_rdata, m1_rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [3:0]        ram_wenable;
    logic [31:0]       ram_rdata;
`ifdef RAM_ARB_STATS_EN
    logic [31:0]       stat_gnt0, stat_gnt1, stat_conflict;
`endif

    ram_arbiter #(.ADDR_W(ADDR_W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_lock(m0_lock), .m0_we(m0_we), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_lock(m1_lock), .m1_we(m1_we), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wenable(ram_wenable),
        .ram_rdata(ram_rdata)
`ifdef RAM_ARB_STATS_EN
        , .stat_gnt0(stat_gnt0), .stat_gnt1(stat_gnt1), .stat_conflict(stat_conflict)
`endif
    );

    // word_ram environment: combinational read, byte-enabled write.
    logic [31:0] mem    [DEPTH];
    logic [31:0] shadow [DEPTH];

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        end
        return r;
    endfunction

    assign ram_rdata = mem[ram_addr];

    always @(posedge clk) begin
        if (ram_wenable != 4'b0000) mem[ram_addr] <= merge(mem[ram_addr], ram_wdata, ram_wenable);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model state (owner -1 means nobody holds the lock).
    int          m_last, m_owner, m_hold;
    bit          m_pend [2];
    logic [31:0] m_rd   [2];
    logic [31:0] m_addr_held, m_wdata_held;
    logic [31:0] m_sg0, m_sg1, m_sconf;

    // Observations from the most recent step.
    logic obs_g0, obs_g1, obs_rv0, obs_rv1;
    logic [31:0] obs_rd0, obs_rd1;

    function automatic logic req_of(input int m);
        return (m == 0) ? m0_req : m1_req;
    endfunction
    function automatic logic lock_of(input int m);
        return (m == 0) ? m0_lock : m1_lock;
    endfunction
    function automatic logic [3:0] we_of(input int m);
        return (m == 0) ? m0_we : m1_we;
    endfunction
    function automatic logic [31:0] addr_of(input int m);
        return (m == 0) ? m0_addr : m1_addr;
    endfunction
    function automatic logic [31:0] wdata_of(input int m);
        return (m == 0) ? m0_wdata : m1_wdata;
    endfunction
    function automatic int word_of(input logic [31:0] a);
        return int'(a[ADDR_W+1:2]);
    endfunction

    task automatic model_reset();
        m_last = 1; m_owner = -1; m_hold = 0;
        m_pend[0] = 0; m_pend[1] = 0;
        m_rd[0] = '0; m_rd[1] = '0;
        m_addr_held = '0; m_wdata_held = '0;
        m_sg0 = '0; m_sg1 = '0; m_sconf = '0;
    endtask

    function automatic bit model_forced();
        return (m_hold == MAX_HOLD) && req_of(1 - m_last);
    endfunction

    // Who should own the RAM this cycle, from the arbitration rules.
    function automatic int model_pick();
        if (model_forced()) return 1 - m_last;
        if (m_owner >= 0) return req_of(m_owner) ? m_owner : -1;
        if (m0_req && m1_req) return 1 - m_last;
        if (m0_req) return 0;
        if (m1_req) return 1;
        return -1;
    endfunction

    // One clock cycle: check DUT against model, then advance the model.
    task automatic step();
        int g;
        bit forced;
        logic [31:0] ea, ew;
        logic [3:0]  ewe;
        @(negedge clk);
        g      = model_pick();
        forced = model_forced();
        obs_g0 = m0_gnt; obs_g1 = m1_gnt;
        obs_rv0 = m0_rvalid; obs_rv1 = m1_rvalid;
        obs_rd0 = m0_rdata;  obs_rd1 = m1_rdata;
        chk("m0_gnt", 32'(m0_gnt), 32'(g == 0));
        chk("m1_gnt", 32'(m1_gnt), 32'(g == 1));
        chk("m0_rvalid", 32'(m0_rvalid), 32'(m_pend[0]));
        chk("m1_rvalid", 32'(m1_rvalid), 32'(m_pend[1]));
        chk("m0_rdata", m0_rdata, m_rd[0]);
        chk("m1_rdata", m1_rdata, m_rd[1]);
        if (g >= 0) begin
            ea = 32'(word_of(addr_of(g))); ew = wdata_of(g); ewe = we_of(g);
        end else begin
            ea = m_addr_held; ew = m_wdata_held; ewe = 4'b0000;
        end
        chk("ram_addr", 32'(ram_addr), ea);
        chk("ram_wdata", ram_wdata, ew);
        chk("ram_wenable", 32'(ram_wenable), 32'(ewe));
`ifdef RAM_ARB_STATS_EN
        chk("stat_gnt0", stat_gnt0, m_sg0);
        chk("stat_gnt1", stat_gnt1, m_sg1);
        chk("stat_conflict", stat_conflict, m_sconf);
`endif
        if ((m0_req && g != 0) || (m1_req && g != 1)) m_sconf = m_sconf + 32'd1;
        m_pend[0] = 0; m_pend[1] = 0;
        if (g >= 0) begin
            if (g == 0) m_sg0 = m_sg0 + 32'd1; else m_sg1 = m_sg1 + 32'd1;
            if (forced) begin
                m_owner = -1; m_hold = 0;
            end else begin
                m_owner = lock_of(g) ? g : -1;
                if (g == m_last && req_of(1 - g))
                    m_hold = (m_hold + 1 > MAX_HOLD) ? MAX_HOLD : m_hold + 1;
                else
                    m_hold = 0;
            end
            m_last = g;
            m_addr_held = ea; m_wdata_held = ew;
            if (ewe == 4'b0000) begin
                m_pend[g] = 1;
                m_rd[g] = shadow[word_of(addr_of(g))];
            end else begin
                shadow[word_of(addr_of(g))] = merge(shadow[word_of(addr_of(g))], ew, ewe);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic idle_inputs();
        m0_req = 0; m0_lock = 0; m0_we = 4'b0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_lock = 0; m1_we = 4'b0; m1_addr = '0; m1_wdata = '0;
    endtask

    // Assert reset, check the immediate reset values, then release.
    task automatic reset_dut();
        rst = 1'b1;
        idle_inputs();
        #1;
        chk("rst_gnt", 32'({m0_gnt, m1_gnt}), 32'd0);
        chk("rst_rvalid", 32'({m0_rvalid, m1_rvalid}), 32'd0);
        chk("rst_rdata", m0_rdata | m1_rdata, 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ram_wdata", ram_wdata, 32'd0);
        chk("rst_ram_wenable", 32'(ram_wenable), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    int cnt;
    logic [31:0] r;

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            r = $urandom();
            mem[i] = r; shadow[i] = r;
        end
        mem[16] = 32'hDEADBEEF;  shadow[16] = 32'hDEADBEEF;
        mem[32] = 32'hAAAAAAAA;  shadow[32] = 32'hAAAAAAAA;
        rst = 1'b1;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_dut();

        // Single read of word 0x10 through the RAM window.
        m0_req = 1; m0_addr = 32'h8000_0040;
        step();
        chk("t1_gnt", 32'(obs_g0), 32'd1);
        idle_inputs();
        step();
        chk("t1_rvalid", 32'(obs_rv0), 32'd1);
        chk("t1_rdata", obs_rd0, 32'hDEADBEEF);
        step();
        chk("t1_rvalid_once", 32'(obs_rv0), 32'd0);

        // Continuous contention alternates m0, m1, m0, ...
        reset_dut();
        for (int k = 0; k < 8; k++) begin
            m0_req = 1; m0_addr = 32'(k) << 2;
            m1_req = 1; m1_addr = 32'(100 + k) << 2;
            step();
            chk("rr_m0", 32'(obs_g0), 32'((k % 2) == 0));
        end
        idle_inputs();
        step();

        // Partial write then read-back.
        m1_req = 1; m1_we = 4'b0011; m1_addr = 32'h0000_0080; m1_wdata = 32'h12345678;
        step();
        m1_we = 4'b0000;
        step();
        idle_inputs();
        step();
        chk("wr_readback", obs_rd1, 32'hAAAA5678);

        // Lock held against a contending master until the hold limit forces a switch.
        reset_dut();
        cnt = 0;
        m0_req = 1; m0_lock = 1; m1_req = 1;
        for (int k = 0; k < 10; k++) begin
            step();
            if (k < 9 && obs_g0) cnt++;
            if (k == 9) chk("starve_m1", 32'(obs_g1), 32'd1);
        end
        chk("lock_run", 32'(cnt), 32'd9);
        m0_req = 0; m0_lock = 0;
        step();
        chk("post_starve_idle", 32'(obs_g1), 32'd1);

        // Lock owner absent: nobody is granted.
        reset_dut();
        m1_req = 1; m1_lock = 1;
        step();
        chk("lock1_gnt", 32'(obs_g1), 32'd1);
        m1_req = 0; m0_req = 1; m0_we = 4'hF; m0_wdata = 32'h5555_5555;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("lock1_wait", 32'({obs_g0, obs_g1}), 32'd0);
        end
        m1_req = 1; m1_lock = 0;
        step();
        chk("lock1_return", 32'(obs_g1), 32'd1);
        idle_inputs();
        step();

        // Reset arriving in the cycle a read is granted.
        m0_req = 1; m0_addr = 32'h8000_0044;
        @(negedge clk);
        chk("rr_pre_gnt", 32'(m0_gnt), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rr_mid_gnt", 32'(m0_gnt), 32'd0);
        chk("rr_mid_ram_addr", 32'(ram_addr), 32'd0);
        chk("rr_mid_wenable", 32'(ram_wenable), 32'd0);
        @(posedge clk); #1;
        chk("rr_drop_rvalid", 32'(m0_rvalid), 32'd0);
        chk("rr_drop_rdata", m0_rdata, 32'd0);
        rst = 1'b0;
        model_reset();
        m1_req = 1; m1_addr = 32'h0000_0048;
        step();
        chk("tie_after_rst", 32'(obs_g0), 32'd1);
        idle_inputs();
        step();

`ifdef RAM_ARB_STATS_EN
        // Ten contended cycles split evenly.
        reset_dut();
        m0_req = 1; m1_req = 1;
        repeat (10) step();
        chk("stats_gnt0", stat_gnt0, 32'd5);
        chk("stats_gnt1", stat_gnt1, 32'd5);
        chk("stats_conflict", stat_conflict, 32'd10);
        idle_inputs();
        step();
`endif

        // Randomized traffic over a small word window.
        reset_dut();
        for (int k = 0; k < 1500; k++) begin
            r = $urandom();
            m0_req  = (r[1:0] != 2'b00);
            m0_lock = (r[3:2] == 2'b00);
            m0_we   = r[4] ? r[8:5] : 4'b0000;
            m1_req  = (r[10:9] != 2'b00);
            m1_lock = (r[12:11] == 2'b00);
            m1_we   = r[13] ? r[17:14] : 4'b0000;
            r = $urandom();
            m0_addr = {r[31:17], 11'd0, r[5:2], r[1:0]};
            r = $urandom();
            m1_addr = {r[31:17], 11'd0, r[5:2], r[1:0]};
            m0_wdata = $urandom();
            m1_wdata = $urandom();
            step();
        end
        idle_inputs();
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Safety net against a stuck run.
    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares one word_ram port between two data requesters: m0 is the cpu data port (RAM window, data_addr[31]=1) and m1 is a secondary master (DMA/loader/debug).
- Grant decision is combinational within the cycle, alternating round-robin.
- Provides a lock for atomic multi-word sequences and a starvation limit.
- Read data is registered: rvalid and rdata arrive 1 cycle after the grant.
- Sits between the cpu/DMA and word_ram; the ROM/MMIO decode stays outside.

Parameters:
- ADDR_W, 15, RAM word-address width; ram_addr = mX_addr[ADDR_W+1:2].
- MAX_HOLD, 8, maximum consecutive grants to one master while the other is requesting; range 1..255.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- m0_req  in  1  m0 access request, held until granted.
- m0_lock  in  1  m0 asks to keep ownership after the current access.
- m0_we  in  4  m0 byte write enables; 0 = read.
- m0_addr  in  32  m0 byte address; bits [1:0] ignored.
- m0_wdata  in  32  m0 write data.
- m0_gnt  out  1  m0 access accepted this cycle.
- m0_rvalid  out  1  m0 read data valid.
- m0_rdata  out  32  m0 read data.
- m1_req, m1_lock, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as the m0 ports, for m1.
- ram_addr  out  ADDR_W  word_ram address.
- ram_wdata  out  32  word_ram write data.
- ram_wenable  out  4  word_ram byte enables.
- ram_rdata  in  32  word_ram combinational read data.

Behaviour:
- State is held in registers:
  - last (1 bit): most recent grantee.
  - lock_own (IDLE/LOCK0/LOCK1).
  - hold_cnt (8 bits).
  - rvalid flags and the rdata register for each master.
- Reset values:
  - last = 1, so m0 wins the first tie.
  - lock_own = IDLE, hold_cnt = 0.
  - gnt = 0, rvalid = 0, rdata = 0.
  - ram_wenable = 0, ram_addr = 0, ram_wdata = 0.
- Reset takes effect immediately. An in-flight read is dropped (no rvalid), and a write in the reset cycle is suppressed.
- Grant selection (combinational) for cycle t:
  - LOCKx and mx_req: grant x. Other master waits, unless the starvation limit forces a switch.
  - LOCKx and !mx_req: no grant, hold the lock; the other master also waits.
  - IDLE, one request: grant it.
  - IDLE, both requesting: grant the master opposite to `last`.
  - Starvation override: hold_cnt == MAX_HOLD and the other master requesting → grant the other master, ignoring lock and round-robin.
- Bus mux:
  - The granted master drives ram_addr, ram_wdata and ram_wenable = mX_we.
  - With no grant: ram_wenable = 0, and ram_addr/ram_wdata are held at their last value.
- Writes commit at the posedge ending cycle t and produce no rvalid.
- Reads (we == 0): ram_rdata is captured at the posedge ending cycle t; mX_rvalid = 1 for exactly cycle t+1. Throughput is one access per cycle.
- On each grant:
  - last ← grantee.
  - lock_own ← LOCKx if mx_lock = 1, else IDLE.
  - hold_cnt ← hold_cnt+1 if the grantee equals last and the other master is requesting; otherwise 0.
  - hold_cnt saturates at MAX_HOLD.
- When the override fires, lock_own → IDLE and hold_cnt → 0; the preempted master re-requests.
- Cycles with no grant: hold_cnt is unchanged.
- Requests may drop without a grant; this is legal, and no state changes for that master.

Optional Feature:
- Macro: RAM_ARB_STATS_EN.
- Defined: adds outputs stat_gnt0, stat_gnt1, stat_conflict (32 bits each, reset 0).
  - stat_gnt0/stat_gnt1 count grants per master.
  - stat_conflict counts cycles where a request was pending but not granted.
  - All counters wrap at 2^32.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then m0 reads word 0x10 (RAM preloaded 0xDEADBEEF) → m0_gnt same cycle, m0_rvalid=1 and m0_rdata=0xDEADBEEF the next cycle only.
- Both masters request continuously, no lock → grant order m0,m1,m0,m1…; each rvalid lands on the correct master.
- m1 writes 0x12345678 with we=4'b0011 to a word holding 0xAAAAAAAA → read back gives 0xAAAA5678.
- m0 asserts lock while m1 requests continuously; MAX_HOLD=8 → m0 gets 9 consecutive grants (1 + 8 counted), then m1 is forced a grant and lock_own=IDLE.
- LOCK1 with m1_req dropped for 3 cycles while m0 requests → no grants and ram_wenable=0 for those 3 cycles; m1 regains the grant on its return.
- Assert rst during the cycle a read is granted → no rvalid afterwards, all outputs 0; the first tie after release goes to m0.
- With RAM_ARB_STATS_EN: 10 contended cycles → stat_gnt0=5, stat_gnt1=5, stat_conflict=10.
